// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: shared widths, flags and the opcode enum used on the RS->ALU interface
package alu_exec_pkg;
   localparam int DATA_WIDTH         = 32;
   localparam int ADDR_WIDTH         = 32;
   localparam int ROB_WRAP_POS_WIDTH = 5;
   localparam int OPENUM_WIDTH       = 6;
   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;
   typedef enum logic [OPENUM_WIDTH-1:0] {
      OP_NOP, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
      OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
      OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
   } openum_t;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational openum -> {val, jump, next_pc}
module alu_core
   import alu_exec_pkg::*;
#(
   parameter int DATA_W   = DATA_WIDTH,
   parameter int OPENUM_W = OPENUM_WIDTH
) (
   input  logic [OPENUM_W-1:0] openum,
   input  logic [DATA_W-1:0]   rs1,
   input  logic [DATA_W-1:0]   rs2,
   input  logic [DATA_W-1:0]   imm,
   input  logic [DATA_W-1:0]   pc,
   output logic [DATA_W-1:0]   val,
   output logic                jump,
   output logic [DATA_W-1:0]   next_pc
);
   openum_t           op;
   logic              imm_op, eq, lts, ltu, taken;
   logic [DATA_W-1:0] op2, pc4, pc_imm, jalr_sum;
   logic [4:0]        shamt;
   assign op       = openum_t'(openum);
   assign imm_op   = op inside {[OP_ADDI:OP_SRAI]};
   assign op2      = imm_op ? imm : rs2;
   assign shamt    = op2[4:0];
   assign pc4      = pc + DATA_W'(4);
   assign pc_imm   = pc + imm;
   assign jalr_sum = rs1 + imm;
   assign eq       = rs1 == op2;
   assign lts      = $signed(rs1) < $signed(op2);
   assign ltu      = rs1 < op2;
   assign taken    = (op == OP_BEQ)  ? eq   :
                     (op == OP_BNE)  ? !eq  :
                     (op == OP_BLT)  ? lts  :
                     (op == OP_BGE)  ? !lts :
                     (op == OP_BLTU) ? ltu  : !ltu;
   // anything not listed (loads/stores/NOP/undefined) still completes with val 0, pc+4
   always_comb begin
      val     = '0;
      jump    = FALSE;
      next_pc = pc4;
      case (op)
         OP_LUI:   val = imm;
         OP_AUIPC: val = pc_imm;
         OP_JAL: begin
            val     = pc4;
            jump    = TRUE;
            next_pc = pc_imm;
         end
         OP_JALR: begin
            val     = pc4;
            jump    = TRUE;
            next_pc = jalr_sum & ~DATA_W'(1);
         end
         OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
            jump    = taken;
            next_pc = taken ? pc_imm : pc4;
         end
         OP_ADD, OP_ADDI:   val = rs1 + op2;
         OP_SUB:            val = rs1 - op2;
         OP_SLL, OP_SLLI:   val = rs1 << shamt;
         OP_SRL, OP_SRLI:   val = rs1 >> shamt;
         OP_SRA, OP_SRAI:   val = $signed(rs1) >>> shamt;
         OP_SLT, OP_SLTI:   val = DATA_W'(lts);
         OP_SLTU, OP_SLTIU: val = DATA_W'(ltu);
         OP_XOR, OP_XORI:   val = rs1 ^ op2;
         OP_OR, OP_ORI:     val = rs1 | op2;
         OP_AND, OP_ANDI:   val = rs1 & op2;
         default: ;
      endcase
   end
endmodule

// File: rtl/alu_exec.sv
// alu_exec: registers alu_core results onto the one-cycle result bus with rst/clr/rdy control
module alu_exec
   import alu_exec_pkg::*;
#(
   parameter int DATA_W    = DATA_WIDTH,
   parameter int ROB_POS_W = ROB_WRAP_POS_WIDTH,
   parameter int OPENUM_W  = OPENUM_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic                 clr,
   input  logic                 rs_to_alu_enable,
   input  logic [OPENUM_W-1:0]  rs_to_alu_openum,
   input  logic [ROB_POS_W-1:0] rs_to_alu_rob_pos,
   input  logic [DATA_W-1:0]    rs_to_alu_rs1_val,
   input  logic [DATA_W-1:0]    rs_to_alu_rs2_val,
   input  logic [DATA_W-1:0]    rs_to_alu_imm,
   input  logic [DATA_W-1:0]    rs_to_alu_pc,
   output logic                 alu_result_ready,
   output logic [ROB_POS_W-1:0] alu_result_rob_pos,
   output logic [DATA_W-1:0]    alu_result_val,
   output logic                 alu_result_jump,
   output logic [DATA_W-1:0]    alu_result_pc
);
   logic [DATA_W-1:0] core_val, core_pc;
   logic              core_jump;
   alu_core #(.DATA_W(DATA_W), .OPENUM_W(OPENUM_W)) u_core (
      .openum  (rs_to_alu_openum),
      .rs1     (rs_to_alu_rs1_val),
      .rs2     (rs_to_alu_rs2_val),
      .imm     (rs_to_alu_imm),
      .pc      (rs_to_alu_pc),
      .val     (core_val),
      .jump    (core_jump),
      .next_pc (core_pc)
   );
   // tag 0 means "no producer", so it is never allowed onto the bus
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_result_ready   <= FALSE;
         alu_result_rob_pos <= '0;
         alu_result_val     <= '0;
         alu_result_jump    <= FALSE;
         alu_result_pc      <= '0;
      end else if (clr) begin
         alu_result_ready <= FALSE;
      end else if (rdy) begin
         alu_result_ready <= rs_to_alu_enable && (rs_to_alu_rob_pos != '0);
         if (rs_to_alu_enable) begin
            alu_result_rob_pos <= rs_to_alu_rob_pos;
            alu_result_val     <= core_val;
            alu_result_jump    <= core_jump;
            alu_result_pc      <= core_pc;
         end
      end
   end
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: vector table, directed pipeline/control sequences and a random run against a reference model
module tb_alu_exec;
   import alu_exec_pkg::*;
   logic        clk, rst, rdy, clr;
   logic        rs_to_alu_enable;
   logic [5:0]  rs_to_alu_openum;
   logic [4:0]  rs_to_alu_rob_pos;
   logic [31:0] rs_to_alu_rs1_val, rs_to_alu_rs2_val, rs_to_alu_imm, rs_to_alu_pc;
   logic        alu_result_ready, alu_result_jump;
   logic [4:0]  alu_result_rob_pos;
   logic [31:0] alu_result_val, alu_result_pc;
   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [5:0]  op;
      logic [31:0] a, b, imm, pc, val, npc;
      logic        jump;
   } vec_t;
   typedef struct {
      logic [31:0] val, npc;
      logic        jump;
   } res_t;

   alu_exec dut (
      .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
      .rs_to_alu_enable(rs_to_alu_enable), .rs_to_alu_openum(rs_to_alu_openum),
      .rs_to_alu_rob_pos(rs_to_alu_rob_pos), .rs_to_alu_rs1_val(rs_to_alu_rs1_val),
      .rs_to_alu_rs2_val(rs_to_alu_rs2_val), .rs_to_alu_imm(rs_to_alu_imm),
      .rs_to_alu_pc(rs_to_alu_pc), .alu_result_ready(alu_result_ready),
      .alu_result_rob_pos(alu_result_rob_pos), .alu_result_val(alu_result_val),
      .alu_result_jump(alu_result_jump), .alu_result_pc(alu_result_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural reference using wide integer arithmetic
   function automatic res_t model(input logic [5:0] op, input logic [31:0] a, b, imm, pc);
      res_t r;
      logic [31:0] o2;
      longint sx, so2, ux, uo2, p, t;
      logic c;
      o2  = (op >= OP_ADDI && op <= OP_SRAI) ? imm : b;
      sx  = longint'($signed(a));
      so2 = longint'($signed(o2));
      ux  = longint'(a);
      uo2 = longint'(o2);
      p   = longint'(1) << (o2 % 32);
      r.val  = 32'h0;
      r.npc  = pc + 32'd4;
      r.jump = 1'b0;
      c = 1'b0;
      case (op)
         OP_LUI:   r.val = imm;
         OP_AUIPC: r.val = pc + imm;
         OP_JAL: begin r.val = pc + 32'd4; r.jump = 1'b1; r.npc = pc + imm; end
         OP_JALR: begin
            r.val = pc + 32'd4; r.jump = 1'b1;
            t = (ux + longint'(imm)) % (longint'(1) << 32);
            r.npc = 32'(t - t % 2);
         end
         OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
            case (op)
               OP_BEQ:  c = a == b;
               OP_BNE:  c = a != b;
               OP_BLT:  c = sx < so2;
               OP_BGE:  c = sx >= so2;
               OP_BLTU: c = ux < uo2;
               default: c = ux >= uo2;
            endcase
            r.jump = c;
            if (c) r.npc = pc + imm;
         end
         OP_ADD, OP_ADDI:   r.val = 32'(ux + uo2);
         OP_SUB:            r.val = 32'(ux - uo2);
         OP_SLL, OP_SLLI:   r.val = 32'(ux * p);
         OP_SRL, OP_SRLI:   r.val = 32'(ux / p);
         OP_SRA, OP_SRAI:   r.val = 32'(sx >= 0 ? sx / p : -((-sx + p - 1) / p));
         OP_SLT, OP_SLTI:   r.val = {31'b0, sx < so2};
         OP_SLTU, OP_SLTIU: r.val = {31'b0, ux < uo2};
         OP_XOR, OP_XORI:   r.val = a ^ o2;
         OP_OR, OP_ORI:     r.val = a | o2;
         OP_AND, OP_ANDI:   r.val = a & o2;
         default: ;
      endcase
      return r;
   endfunction

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   task automatic chk_out(input string n, input logic r, input logic [4:0] t,
                          input logic [31:0] val, input logic j, input logic [31:0] npc);
      chk({n, ".ready"}, 32'(alu_result_ready), 32'(r));
      chk({n, ".tag"}, 32'(alu_result_rob_pos), 32'(t));
      chk({n, ".val"}, alu_result_val, val);
      chk({n, ".jump"}, 32'(alu_result_jump), 32'(j));
      chk({n, ".pc"}, alu_result_pc, npc);
   endtask

   task automatic send(input logic [5:0] op, input logic [31:0] a, b, imm, pc,
                       input logic [4:0] tag, input logic en);
      rs_to_alu_openum  = op;
      rs_to_alu_rs1_val = a;
      rs_to_alu_rs2_val = b;
      rs_to_alu_imm     = imm;
      rs_to_alu_pc      = pc;
      rs_to_alu_rob_pos = tag;
      rs_to_alu_enable  = en;
   endtask

   initial begin
      vec_t v[15];
      res_t exp_r;
      logic pend;
      logic [4:0] exp_tag, tag;
      logic [5:0] op;
      logic [31:0] a, b, imm, pc, rnd;
      logic en;
      v[0]  = '{OP_ADD,   32'h7FFFFFFF, 32'h1,        32'h0,        32'h0,   32'h80000000, 32'h4,   1'b0};
      v[1]  = '{OP_SRA,   32'h80000010, 32'h24,       32'h0,        32'h8,   32'hF8000001, 32'hC,   1'b0};
      v[2]  = '{OP_SRL,   32'h80000010, 32'h24,       32'h0,        32'hC,   32'h08000001, 32'h10,  1'b0};
      v[3]  = '{OP_BLTU,  32'h1,        32'hFFFFFFFF, 32'hFFFFFFF8, 32'h100, 32'h0,        32'hF8,  1'b1};
      v[4]  = '{OP_BLT,   32'h1,        32'hFFFFFFFF, 32'hFFFFFFF8, 32'h100, 32'h0,        32'h104, 1'b0};
      v[5]  = '{OP_JALR,  32'h1003,     32'h0,        32'h4,        32'h40,  32'h44,       32'h1006, 1'b1};
      v[6]  = '{OP_LUI,   32'h5,        32'h0,        32'h12345000, 32'h20,  32'h12345000, 32'h24,  1'b0};
      v[7]  = '{OP_AUIPC, 32'h0,        32'h0,        32'h1000,     32'h200, 32'h1200,     32'h204, 1'b0};
      v[8]  = '{OP_JAL,   32'h0,        32'h0,        32'hFFFFFFF0, 32'h300, 32'h304,      32'h2F0, 1'b1};
      v[9]  = '{OP_LW,    32'h5,        32'h6,        32'h8,        32'h10,  32'h0,        32'h14,  1'b0};
      v[10] = '{OP_SUB,   32'h3,        32'h5,        32'h0,        32'h0,   32'hFFFFFFFE, 32'h4,   1'b0};
      v[11] = '{OP_SLTIU, 32'h5,        32'h0,        32'hFFFFFFFF, 32'h0,   32'h1,        32'h4,   1'b0};
      v[12] = '{OP_BGE,   32'hFFFFFFFD, 32'hFFFFFFFD, 32'h20,       32'h50,  32'h0,        32'h70,  1'b1};
      v[13] = '{OP_SRAI,  32'h80000000, 32'h0,        32'h41F,      32'h0,   32'hFFFFFFFF, 32'h4,   1'b0};
      v[14] = '{OP_SLT,   32'hFFFFFFFF, 32'h1,        32'h0,        32'h0,   32'h1,        32'h4,   1'b0};

      rst = 1'b1; rdy = 1'b1; clr = 1'b0;
      send(OP_ADD, 32'h1, 32'h2, 32'h0, 32'h0, 5'd7, 1'b1);
      repeat (3) @(negedge clk);
      chk_out("reset", 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
      rst = 1'b0;
      rs_to_alu_enable = 1'b0;
      @(negedge clk);

      foreach (v[i]) begin
         send(v[i].op, v[i].a, v[i].b, v[i].imm, v[i].pc, 5'(i + 1), 1'b1);
         @(negedge clk);
         chk_out($sformatf("vec%0d", i), 1'b1, 5'(i + 1), v[i].val, v[i].jump, v[i].npc);
         rs_to_alu_enable = 1'b0;
         @(negedge clk);
         chk($sformatf("vec%0d.idle", i), 32'(alu_result_ready), 32'h0);
      end

      // back-to-back tags 1,2,3
      for (int i = 1; i <= 3; i++) begin
         send(OP_ADD, 32'(i), 32'(i), 32'h0, 32'h0, 5'(i), 1'b1);
         @(negedge clk);
         chk_out($sformatf("b2b%0d", i), 1'b1, 5'(i), 32'(2 * i), 1'b0, 32'h4);
      end
      rs_to_alu_enable = 1'b0;
      @(negedge clk);
      chk("b2b.idle", 32'(alu_result_ready), 32'h0);

      // rdy low on the second edge: tag 1 held, tag 2 dropped
      send(OP_ADD, 32'h1, 32'h1, 32'h0, 32'h0, 5'd1, 1'b1);
      @(negedge clk);
      chk_out("hold.t1", 1'b1, 5'd1, 32'h2, 1'b0, 32'h4);
      send(OP_ADD, 32'h2, 32'h2, 32'h0, 32'h0, 5'd2, 1'b1);
      rdy = 1'b0;
      @(negedge clk);
      chk_out("hold.kept", 1'b1, 5'd1, 32'h2, 1'b0, 32'h4);
      rdy = 1'b1;
      send(OP_ADD, 32'h3, 32'h3, 32'h0, 32'h0, 5'd3, 1'b1);
      @(negedge clk);
      chk_out("hold.t3", 1'b1, 5'd3, 32'h6, 1'b0, 32'h4);

      // clr discards the same-edge dispatch, with and without rdy
      send(OP_ADD, 32'h5, 32'h5, 32'h0, 32'h0, 5'd6, 1'b1);
      clr = 1'b1;
      @(negedge clk);
      chk("clr.ready", 32'(alu_result_ready), 32'h0);
      clr = 1'b0;
      send(OP_ADD, 32'h7, 32'h7, 32'h0, 32'h0, 5'd7, 1'b1);
      @(negedge clk);
      chk_out("clr.after", 1'b1, 5'd7, 32'hE, 1'b0, 32'h4);
      clr = 1'b1; rdy = 1'b0;
      send(OP_ADD, 32'h8, 32'h8, 32'h0, 32'h0, 5'd8, 1'b1);
      @(negedge clk);
      chk("clr.nordy", 32'(alu_result_ready), 32'h0);
      clr = 1'b0; rdy = 1'b1;

      // reset mid-stream
      send(OP_JAL, 32'h0, 32'h0, 32'h40, 32'h80, 5'd9, 1'b1);
      @(negedge clk);
      chk_out("mid.pre", 1'b1, 5'd9, 32'h84, 1'b1, 32'hC0);
      send(OP_ADD, 32'h1, 32'h1, 32'h0, 32'h0, 5'd10, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      chk_out("mid.rst", 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
      rst = 1'b0;
      rs_to_alu_enable = 1'b0;

      // random back-to-back traffic against the reference model
      pend = 1'b0;
      exp_tag = '0;
      exp_r = '{32'h0, 32'h0, 1'b0};
      for (int n = 0; n < 400; n++) begin
         if (pend) chk_out($sformatf("rand%0d", n), 1'b1, exp_tag, exp_r.val, exp_r.jump, exp_r.npc);
         else chk($sformatf("rand%0d.idle", n), 32'(alu_result_ready), 32'h0);
         op  = 6'($urandom_range(0, 45));
         a   = $urandom;
         b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
         rnd = $urandom;
         imm = ($urandom_range(0, 1) == 1) ? rnd : {{20{rnd[11]}}, rnd[11:0]};
         pc  = $urandom & 32'hFFFFFFFC;
         tag = 5'($urandom_range(1, 31));
         en  = $urandom_range(0, 3) != 0;
         send(op, a, b, imm, pc, tag, en);
         pend = en;
         exp_tag = tag;
         exp_r = model(op, a, b, imm, pc);
         @(negedge clk);
      end
      if (pend) chk_out("rand.last", 1'b1, exp_tag, exp_r.val, exp_r.jump, exp_r.npc);
      else chk("rand.last.idle", 32'(alu_result_ready), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execution unit at the far end of the RS→ALU dispatch interface.
- Accepts one ready instruction per cycle from the reservation station: opcode enum, operand values, immediate, PC, ROB tag.
- Computes the integer result and branch/jump outcome, then broadcasts one cycle later on the result bus.
- The result bus is consumed by the RS (operand wake-up), the LSB and the ROB (completion and branch redirect).

Parameters:
- DATA_W, 32, operand/result/PC width.
- ROB_POS_W, 5, ROB wrap-position tag width; tag 0 is reserved for "no producer" and is never broadcast.
- OPENUM_W, 6, width of the shared opcode enum.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; when low, all state holds
- clr  in  1  misprediction flush, synchronous
- rs_to_alu_enable  in  1  dispatch valid
- rs_to_alu_openum  in  OPENUM_W  operation enum
- rs_to_alu_rob_pos  in  ROB_POS_W  destination ROB tag
- rs_to_alu_rs1_val  in  DATA_W  operand 1
- rs_to_alu_rs2_val  in  DATA_W  operand 2
- rs_to_alu_imm  in  DATA_W  sign-extended immediate
- rs_to_alu_pc  in  DATA_W  instruction PC
- alu_result_ready  out  1  broadcast valid
- alu_result_rob_pos  out  ROB_POS_W  broadcast tag
- alu_result_val  out  DATA_W  value written to rd
- alu_result_jump  out  1  control transfer taken
- alu_result_pc  out  DATA_W  next PC (target if taken, else pc+4)

Behaviour:
- Reset: the reset value of every output is 0.
- clr: on any rising edge with clr high, regardless of rdy, alu_result_ready goes to 0. The instruction dispatched in that cycle is discarded.
- rdy low with rst and clr both low: all output registers hold; the dispatch in that cycle is dropped.
- Latency:
  - Dispatch sampled at edge N (enable high, rdy high, no rst/clr).
  - Result is visible after edge N and valid for exactly one cycle.
  - If the following cycle has no dispatch, alu_result_ready returns to 0.
- Throughput: one instruction per cycle, no backpressure, no internal queue. The RS never needs to stall the ALU.
- Operand selection:
  - Register-register ops use rs1/rs2.
  - Immediate ops use rs1/imm.
  - Shift amount is operand2[4:0]; SRA/SRAI are arithmetic.
  - SLT/SLTI are signed compares; SLTU/SLTIU are unsigned.
  - All adds wrap modulo 2^32.
- LUI: val = imm, jump = 0, pc = pc+4.
- AUIPC: val = pc+imm, jump = 0, pc = pc+4.
- JAL: val = pc+4, jump = 1, pc = pc+imm.
- JALR: val = pc+4, jump = 1, pc = (rs1+imm) & ~1.
- Branches (BEQ/BNE/BLT/BGE/BLTU/BGEU):
  - val = 0.
  - jump = condition.
  - pc = condition ? pc+imm : pc+4.
- Non-control ops: jump = 0, pc = pc+4.
- Unknown openum: broadcast with val = 0, jump = 0, pc = pc+4. No hang, tag still completes.
- Dispatch with rob_pos = 0 is illegal. Behaviour is undefined, but the output must not be X.

Decomposition:
- Shared package (existing definition include) holds:
  - openum enum values
  - DATA/ADDR/ROB_WRAP_POS widths
  - TRUE/FALSE
- One natural sub-module, alu_core: purely combinational openum → {val, jump, next_pc}.
- alu_exec owns the output registers and the rst/clr/rdy handling.

Test Plan:
- ADD, rs1=0x7FFFFFFF, rs2=1, rob_pos=3 → next cycle: ready=1, tag=3, val=0x80000000, jump=0; following idle cycle: ready=0.
- SRA rs1=0x80000010, rs2=0x24 followed by SRL same operands → val 0xF8000001 then 0x08000001.
- BLTU rs1=1, rs2=0xFFFFFFFF, pc=0x100, imm=-8 → jump=1, pc=0xF8; BLT same operands → jump=0, pc=0x104.
- JALR rs1=0x1003, imm=4, pc=0x40 → val=0x44, jump=1, pc=0x1006.
- Back-to-back dispatches tags 1,2,3 → three consecutive ready cycles, in order, tags 1,2,3; rdy low on the second edge → tag 1 held, tag 2 dropped, tag 3 follows.
- Dispatch on the same edge as clr → ready=0 next cycle. rst asserted mid-stream → all outputs 0 after the edge.
